// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple slice reused WIDTH/DIGIT times,
// with the inter-digit carry held in a register and flags captured on the last digit.
module serial_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             c;
    logic [WIDTH-1:0] res_next;

    // Ripple through the current digit; slice_cmsb is the carry into the slice's top bit,
    // which on the last digit is the carry into bit WIDTH-1.
    always_comb begin
        slice_sum  = '0;
        c          = carry;
        slice_cmsb = carry;
        for (int j = 0; j < int'(DIGIT); j++) begin
            slice_cmsb   = c;
            slice_sum[j] = a_sr[j] ^ b_sr[j] ^ c;
            c            = (a_sr[j] & b_sr[j]) | (c & (a_sr[j] ^ b_sr[j]));
        end
        slice_cout = c;
        res_next   = res;
        res_next[32'(cnt) * DIGIT +: DIGIT] = slice_sum;
    end

    // Controller and datapath registers; visible results change only when entering DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    carry <= slice_cout;
                    res   <= res_next;
                    if (cnt == CW'(N - 1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= res_next;
                        carryout <= slice_cout;
                        overflow <= slice_cout ^ slice_cmsb;
                        zero     <= (res_next == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed vectors, handshake/reset sequences, random 8-bit ops
// and an exhaustive 4-bit sweep over three digit sizes, all against an arithmetic model.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       st81, st84, st4;
    logic [7:0] a8, b8;
    logic       sub8;
    logic [3:0] a4, b4;
    logic       sub4;

    logic       busy81, done81, co81, ov81, z81;
    logic [7:0] sum81;
    logic       busy84, done84, co84, ov84, z84;
    logic [7:0] sum84;
    logic       busy41, done41, co41, ov41, z41;
    logic [3:0] sum41;
    logic       busy42, done42, co42, ov42, z42;
    logic [3:0] sum42;
    logic       busy44, done44, co44, ov44, z44;
    logic [3:0] sum44;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u81 (
        .clk(clk), .reset_n(reset_n), .start(st81), .sub(sub8), .a(a8), .b(b8),
        .busy(busy81), .done(done81), .sum(sum81), .carryout(co81), .overflow(ov81), .zero(z81));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) u84 (
        .clk(clk), .reset_n(reset_n), .start(st84), .sub(sub8), .a(a8), .b(b8),
        .busy(busy84), .done(done84), .sum(sum84), .carryout(co84), .overflow(ov84), .zero(z84));
    serial_addsub #(.WIDTH(4), .DIGIT(1)) u41 (
        .clk(clk), .reset_n(reset_n), .start(st4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy41), .done(done41), .sum(sum41), .carryout(co41), .overflow(ov41), .zero(z41));
    serial_addsub #(.WIDTH(4), .DIGIT(2)) u42 (
        .clk(clk), .reset_n(reset_n), .start(st4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy42), .done(done42), .sum(sum42), .carryout(co42), .overflow(ov42), .zero(z42));
    serial_addsub #(.WIDTH(4), .DIGIT(4)) u44 (
        .clk(clk), .reset_n(reset_n), .start(st4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy44), .done(done44), .sum(sum44), .carryout(co44), .overflow(ov44), .zero(z44));

    typedef struct {
        bit         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] esum;
        logic       eco;
        logic       eov;
        logic       ez;
    } vec_t;

    vec_t tbl[8];

    // Reference: plain integer arithmetic, returns {sum[7:0], carryout, overflow, zero}.
    function automatic logic [10:0] model(input int w, input int av, input int bv, input bit s);
        int   m, half, sa, sb, r, sr, sm;
        logic co, ov;
        m    = 1 << w;
        half = m / 2;
        sa   = (av >= half) ? av - m : av;
        sb   = (bv >= half) ? bv - m : bv;
        if (s) begin
            r  = av - bv;
            co = (av >= bv);
            sr = sa - sb;
        end else begin
            r  = av + bv;
            co = (r >= m);
            sr = sa + sb;
        end
        ov = (sr >= half) || (sr < -half);
        sm = ((r % m) + m) % m;
        return {8'(sm), co, ov, (sm == 0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic busyf(input bit sel);
        return sel ? busy84 : busy81;
    endfunction

    function automatic logic donef(input bit sel);
        return sel ? done84 : done81;
    endfunction

    function automatic logic [10:0] res8(input bit sel);
        return sel ? {sum84, co84, ov84, z84} : {sum81, co81, ov81, z81};
    endfunction

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic start8(input bit sel, input logic [7:0] av, input logic [7:0] bv, input logic sv);
        a8 = av; b8 = bv; sub8 = sv;
        if (sel) st84 = 1'b1; else st81 = 1'b1;
        @(posedge clk); #1;
        st81 = 1'b0; st84 = 1'b0;
    endtask

    // Count edges to done and busy samples; at step 'poke' corrupt operands and pulse start.
    task automatic wait8(input bit sel, input int poke, output int k, output int bc);
        k  = 0;
        bc = 0;
        if (busyf(sel)) bc++;
        while (!donef(sel) && k < 20) begin
            if (k == poke) begin
                a8 = 8'h11; b8 = 8'h22; sub8 = ~sub8;
                if (sel) st84 = 1'b1; else st81 = 1'b1;
            end
            @(posedge clk); #1;
            k++;
            st81 = 1'b0; st84 = 1'b0;
            if (busyf(sel)) bc++;
        end
    endtask

    task automatic op8(input bit sel, input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       input string name, input int poke, input logic [10:0] exp);
        int k, bc, n;
        n = sel ? 2 : 8;
        start8(sel, av, bv, sv);
        wait8(sel, poke, k, bc);
        chk({name, "_latency"}, 32'(k), 32'(n));
        chk({name, "_busy_cycles"}, 32'(bc), 32'(n));
        chk({name, "_result"}, 32'(res8(sel)), 32'(exp));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 32'(donef(sel)), 32'(0));
    endtask

    initial begin
        int          q[$];
        int          nd;
        logic [10:0] e;
        bit          rs;
        logic [7:0]  ra, rb;
        logic        rsub;

        tbl[0] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{0, 8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1, 8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

        reset_n = 1'b0;
        st81 = 1'b0; st84 = 1'b0; st4 = 1'b0;
        a8 = '0; b8 = '0; sub8 = 1'b0;
        a4 = '0; b4 = '0; sub4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        chk("reset_w8d1", 32'({busy81, done81, sum81, co81, ov81, z81}), 32'({2'b00, 8'h00, 3'b001}));
        chk("reset_w8d4", 32'({busy84, done84, sum84, co84, ov84, z84}), 32'({2'b00, 8'h00, 3'b001}));
        chk("reset_w4d1", 32'({busy41, done41, sum41, co41, ov41, z41}), 32'({2'b00, 4'h0, 3'b001}));
        chk("reset_w4d2", 32'({busy42, done42, sum42, co42, ov42, z42}), 32'({2'b00, 4'h0, 3'b001}));
        chk("reset_w4d4", 32'({busy44, done44, sum44, co44, ov44, z44}), 32'({2'b00, 4'h0, 3'b001}));

        for (int i = 0; i < 8; i++) begin
            op8(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].s, $sformatf("vec%0d", i), -1,
                {tbl[i].esum, tbl[i].eco, tbl[i].eov, tbl[i].ez});
        end

        // start held high: back-to-back operations, done every N+1 cycles
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
        st81 = 1'b1;
        for (int i = 0; i < 40 && q.size() < 3; i++) begin
            @(posedge clk); #1;
            if (done81) q.push_back(cyc);
        end
        st81 = 1'b0;
        chk("b2b_done_count", 32'(q.size()), 32'(3));
        if (q.size() == 3) begin
            chk("b2b_gap0", 32'(q[1] - q[0]), 32'(9));
            chk("b2b_gap1", 32'(q[2] - q[1]), 32'(9));
        end
        chk("b2b_sum", 32'(sum81), 32'(8'h30));
        repeat (12) @(posedge clk);
        #1;

        // start/operand changes while busy must not disturb the running operation
        op8(0, 8'h20, 8'h05, 1'b0, "ignore_d1", 3, model(8, 32'h20, 32'h05, 1'b0));
        op8(1, 8'h90, 8'h10, 1'b1, "ignore_d4", 0, model(8, 32'h90, 32'h10, 1'b1));

        // reset at RUN cycle 3 aborts the operation
        start8(0, 8'h40, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk("midrst_state", 32'({busy81, done81, sum81, z81}), 32'({2'b00, 8'h00, 1'b1}));
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done81) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'(0));
        op8(0, 8'h03, 8'h04, 1'b0, "post_rst", -1, model(8, 3, 4, 1'b0));

        for (int i = 0; i < 40; i++) begin
            rs   = 1'($urandom_range(0, 1));
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rsub = 1'($urandom_range(0, 1));
            op8(rs, ra, rb, rsub, $sformatf("rand%0d", i), -1, model(8, 32'(ra), 32'(rb), rsub));
        end

        // exhaustive 4-bit sweep on all three digit sizes at once
        for (int s = 0; s < 2; s++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    a4 = 4'(av); b4 = 4'(bv); sub4 = 1'(s);
                    st4 = 1'b1;
                    @(posedge clk); #1;
                    st4 = 1'b0;
                    repeat (5) @(posedge clk);
                    #1;
                    e = model(4, av, bv, 1'(s));
                    chk($sformatf("w4d1_%0d_%0d_%0d", av, bv, s), 32'({sum41, co41, ov41, z41}), 32'({e[6:3], e[2:0]}));
                    chk($sformatf("w4d2_%0d_%0d_%0d", av, bv, s), 32'({sum42, co42, ov42, z42}), 32'({e[6:3], e[2:0]}));
                    chk($sformatf("w4d4_%0d_%0d_%0d", av, bv, s), 32'({sum44, co44, ov44, z44}), 32'({e[6:3], e[2:0]}));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
